mxv_relu_seq: RTL and testbench
===============================

# mxv_relu_seq

Sequential fully-connected-layer engine for the fc_layer benchmark family. It computes the same JxK by Kx1 signed matrix-vector product with ReLU as the combinational mxv block. Instead of J*K parallel multipliers, it uses one shared N-bit signed multiplier and one accumulator, and steps through rows and columns under a start/busy/done FSM. It sits between the garbler-side weight bus and evaluator-side activation bus and the next layer, trading J*K cycles of latency for a single multiplier's worth of gates.

## Interface
- N, 8, signed operand bit-width (weights and activations)
- J, 3, output rows (matrix rows)
- K, 3, inner dimension (matrix columns / vector length)
- A (localparam), 2*N+$clog2(K), signed accumulator and per-row output width; exact, no overflow possible
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a computation; sampled only in IDLE
- g_input  input  J*K*N  weights; W[j][k] = g_input[(j*K+k+1)*N-1 -: N], signed
- e_input  input  K*N  activations; X[k] = e_input[(k+1)*N-1 -: N], signed
- busy  output  1  high whenever FSM is not IDLE
- done  output  1  one-cycle pulse, all rows of o final
- o  output  J*A  results; row j = o[(j+1)*A-1 -: A]

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - On a start=1 edge, latch g_input/e_input into internal operand registers, clear acc, clear all of o, set j=0, k=0, and go to MAC.
  - Inputs may change freely after that edge.
- MAC, each edge:
  - p = W[j][k]*X[k], full 2N-bit signed product, sign-extended to A.
  - If k<K-1: acc <= acc+p, k <= k+1.
  - If k==K-1: row j of o <= f(acc+p), acc <= 0, k <= 0.
    - If j<J-1: j <= j+1.
    - Else: go to DONE.
- DONE: done=1 for this cycle, then go to IDLE unconditionally.
- f(x) = (x<0) ? 0 : x when ReLU is compiled in (see Configuration); otherwise f(x) = x.
- start is ignored while busy=1. It is not queued.
- o rows hold their value from completion until the next accepted start. Rows not yet computed read 0.
- Reset values:
  - state=IDLE, busy=0, done=0, o=0, acc=0, j=0, k=0, operand registers 0.
- Reset asserted mid-computation aborts immediately to the reset values. No partial row survives.
- Degenerate J=1 or K=1 must work.
  - K=1: every MAC edge completes a row.
  - Counter widths use $clog2 with a minimum of 1 bit.

## Timing
- Cycle 0: start=1 sampled in IDLE. busy rises after this edge.
- Cycles 1..J*K: MAC. Row j becomes visible on o after the edge ending cycle (j+1)*K.
- Cycle J*K+1: DONE, done=1, busy=1.
- Cycle J*K+2: IDLE, busy=0. A new start is accepted if high in this cycle.
- Start-to-done latency is exactly J*K+1 cycles. Throughput is one job per J*K+2 cycles.
- start held continuously restarts every J*K+2 cycles.
- done is never asserted in any state other than DONE.

## Configuration
- Macro MXV_RELU_EN.
  - Defined: ReLU is applied per row as above. This is the default build for the benchmark.
  - Undefined: rows carry the raw signed sum, including negatives.
- FSM, timing and widths are identical in both builds.

## Test plan
- Reference vectors, ReLU build:
  - Stimulus: W[2]={W[2][2]=-1, W[2][1]=2, W[2][0]=-3}, W[1]={2,3,-4}, W[0]={-4,5,7} (same index order), X[2]=2, X[1]=3, X[0]=-4, start=1 for one cycle.
  - Expected: done exactly 10 cycles later. Row2=16, row1=29, row0=0.
  - Same vectors with MXV_RELU_EN undefined: row0=-21 (sign-extended to A bits).
- Extremes:
  - Stimulus: all W=-128, all X=-128 (N=8).
  - Expected: every row = 3*16384 = 49152, no overflow in A=18 bits.
  - Negated case: all W=-128, X=127 gives 0 with ReLU, -48768 without.
- Start while busy:
  - Stimulus: pulse start again in cycles 3 and 10 with different inputs.
  - Expected: both pulses ignored. Result matches the first operands. Only one done pulse.
- Back-to-back jobs: start held high.
  - Expected: done at cycles 10, 21, 32.
  - Expected: o cleared to 0 on each acceptance edge (cycles 0, 11, 22).
- Reset mid-operation:
  - Stimulus: drop rst_n asynchronously in cycle 5.
  - Expected: busy=0, done=0, o=0 immediately, no done pulse.
  - After release, a new start completes normally with correct values.
- Input change after accept:
  - Stimulus: randomize g_input/e_input every cycle after the start edge.
  - Expected: results equal those for the latched operands.

Source files
------------

// File: rtl/mxv_relu_seq_if.sv
// Operand, control and result bundle for mxv_relu_seq.
// The master drives the job. The slave is the engine.
interface mxv_relu_seq_if #(
    parameter int N = 8,
    parameter int J = 3,
    parameter int K = 3
);
    localparam int A = 2*N + $clog2(K);

    logic             start;
    logic [J*K*N-1:0] g_input;
    logic [K*N-1:0]   e_input;
    logic             busy;
    logic             done;
    logic [J*A-1:0]   o;

    modport master (
        output start, g_input, e_input,
        input  busy, done, o
    );

    modport slave (
        input  start, g_input, e_input,
        output busy, done, o
    );
endinterface

// File: rtl/mxv_relu_seq.sv
// mxv_relu_seq: JxK signed matrix-vector product using one shared multiplier and one accumulator.
// Define MXV_RELU_EN to clamp negative rows to zero; otherwise rows carry the raw signed sum.
module mxv_relu_seq #(
    parameter int N = 8,
    parameter int J = 3,
    parameter int K = 3
) (
    input logic           clk,
    input logic           rst_n,
    mxv_relu_seq_if.slave bus
);
    localparam int A  = 2*N + $clog2(K);
    localparam int JW = (J > 1) ? $clog2(J) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    state_e              state_q;
    logic [J*K*N-1:0]    w_q;
    logic [K*N-1:0]      x_q;
    logic signed [A-1:0] acc_q;
    logic [JW-1:0]       j_q;
    logic [KW-1:0]       k_q;
    logic signed [A-1:0] o_q [J];
    logic                busy_q;
    logic                done_q;

    logic signed [N-1:0]   w_sel;
    logic signed [N-1:0]   x_sel;
    logic signed [2*N-1:0] prod;
    logic signed [A-1:0]   sum_d;
    logic signed [A-1:0]   row_d;

    // Operand select is a compare-and-pick mux so out-of-range counter codes read zero.
    always_comb begin
        w_sel = '0;
        x_sel = '0;
        for (int unsigned jj = 0; jj < J; jj++) begin
            for (int unsigned kk = 0; kk < K; kk++) begin
                if (j_q == JW'(jj) && k_q == KW'(kk)) begin
                    w_sel = w_q[(jj*K + kk)*N +: N];
                end
            end
        end
        for (int unsigned kk = 0; kk < K; kk++) begin
            if (k_q == KW'(kk)) begin
                x_sel = x_q[kk*N +: N];
            end
        end
    end

    always_comb begin
        prod  = w_sel * x_sel;
        sum_d = acc_q + A'(prod);
`ifdef MXV_RELU_EN
        row_d = sum_d[A-1] ? '0 : sum_d;
`else
        row_d = sum_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < J; i++) begin
                o_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        w_q     <= bus.g_input;
                        x_q     <= bus.e_input;
                        acc_q   <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                        for (int unsigned i = 0; i < J; i++) begin
                            o_q[i] <= '0;
                        end
                    end
                end
                MAC: begin
                    if (k_q == KW'(K-1)) begin
                        o_q[j_q] <= row_d;
                        acc_q    <= '0;
                        k_q      <= '0;
                        if (j_q == JW'(J-1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        acc_q <= sum_d;
                        k_q   <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    for (genvar g = 0; g < J; g++) begin : g_rows
        assign bus.o[g*A +: A] = o_q[g];
    end
endmodule

// File: tb/tb_mxv_relu_seq.sv
// Self-checking bench for mxv_relu_seq: random and directed jobs against a plain-arithmetic model.
module tb_mxv_relu_seq;
    localparam int N = 8;
    localparam int J = 3;
    localparam int K = 3;
    localparam int A = 2*N + $clog2(K);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mxv_relu_seq_if #(.N(N), .J(J), .K(K)) bus ();
    mxv_relu_seq #(.N(N), .J(J), .K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    int Wm [J][K];
    int Xv [K];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_operands;
        logic [J*K*N-1:0] g;
        logic [K*N-1:0]   e;
        logic [31:0]      t;
        g = '0;
        e = '0;
        for (int j = 0; j < J; j++)
            for (int k = 0; k < K; k++) begin
                t = Wm[j][k];
                g[(j*K + k)*N +: N] = t[N-1:0];
            end
        for (int k = 0; k < K; k++) begin
            t = Xv[k];
            e[k*N +: N] = t[N-1:0];
        end
        bus.g_input = g;
        bus.e_input = e;
    endtask

    task automatic rand_operands(input int lo, input int hi);
        for (int j = 0; j < J; j++)
            for (int k = 0; k < K; k++)
                Wm[j][k] = lo + int'($urandom_range(hi - lo));
        for (int k = 0; k < K; k++)
            Xv[k] = lo + int'($urandom_range(hi - lo));
    endtask

    task automatic drive_noise;
        logic [95:0] r;
        logic [31:0] r2;
        r  = {$urandom(), $urandom(), $urandom()};
        r2 = $urandom();
        bus.g_input = r[J*K*N-1:0];
        bus.e_input = r2[K*N-1:0];
    endtask

    function automatic logic signed [A-1:0] exp_row(input int j);
        longint      s;
        logic [63:0] t;
        s = 0;
        for (int k = 0; k < K; k++)
            s += longint'(Wm[j][k]) * longint'(Xv[k]);
`ifdef MXV_RELU_EN
        if (s < 0) s = 0;
`endif
        t = 64'(s);
        return t[A-1:0];
    endfunction

    function automatic logic signed [A-1:0] got_row(input int j);
        return bus.o[j*A +: A];
    endfunction

    task automatic start_job;
        drive_operands();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns the cycle number (accept cycle = 0) at which done is seen, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1) begin
            if (cyc >= 40) begin
                cyc = -1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.g_input = '0;
        bus.e_input = '0;
        repeat (3) tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.o !== '0) begin miscompares++; $display("FAIL reset_o: got %h expected 0", bus.o); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reference;
        logic signed [A-1:0] lit [J];
        Wm[2][2] = -1; Wm[2][1] = 2; Wm[2][0] = -3;
        Wm[1][2] =  2; Wm[1][1] = 3; Wm[1][0] = -4;
        Wm[0][2] = -4; Wm[0][1] = 5; Wm[0][0] =  7;
        Xv[2] = 2; Xv[1] = 3; Xv[0] = -4;
        lit[2] = A'(16);
        lit[1] = A'(29);
`ifdef MXV_RELU_EN
        lit[0] = '0;
`else
        lit[0] = A'(-21);
`endif
        start_job();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ref_busy c%0d: got %b expected 1", cyc, bus.busy); end
            vectors++; if (bus.done !== (cyc == 10)) begin miscompares++; $display("FAIL ref_done c%0d: got %b expected %b", cyc, bus.done, cyc == 10); end
            if (cyc == 1) begin
                vectors++; if (bus.o !== '0) begin miscompares++; $display("FAIL ref_clear: got %h expected 0", bus.o); end
            end
            if (cyc == 4) begin
                vectors++; if (got_row(0) !== lit[0]) begin miscompares++; $display("FAIL ref_row0_early: got %0d expected %0d", got_row(0), lit[0]); end
                vectors++; if (got_row(1) !== '0) begin miscompares++; $display("FAIL ref_row1_pending: got %0d expected 0", got_row(1)); end
            end
            if (cyc < 10) tick();
        end
        for (int j = 0; j < J; j++) begin
            vectors++; if (got_row(j) !== lit[j]) begin miscompares++; $display("FAIL ref_row%0d: got %0d expected %0d", j, got_row(j), lit[j]); end
        end
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ref_idle_busy: got %b expected 0", bus.busy); end
        vectors++; if (got_row(1) !== lit[1]) begin miscompares++; $display("FAIL ref_hold: got %0d expected %0d", got_row(1), lit[1]); end
    endtask

    task automatic test_extremes;
        logic signed [A-1:0] lit;
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < J; j++)
                for (int k = 0; k < K; k++) Wm[j][k] = -128;
            for (int k = 0; k < K; k++) Xv[k] = (pass == 0) ? -128 : 127;
            if (pass == 0) lit = A'(49152);
            else begin
`ifdef MXV_RELU_EN
                lit = '0;
`else
                lit = A'(-48768);
`endif
            end
            start_job();
            wait_done(lat);
            vectors++; if (lat !== 10) begin miscompares++; $display("FAIL ext%0d_latency: got %0d expected 10", pass, lat); end
            for (int j = 0; j < J; j++) begin
                vectors++; if (got_row(j) !== lit) begin miscompares++; $display("FAIL ext%0d_row%0d: got %0d expected %0d", pass, j, got_row(j), lit); end
            end
            tick();
        end
    endtask

    task automatic test_start_while_busy;
        int dones;
        rand_operands(-128, 127);
        start_job();
        dones = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (bus.done === 1'b1) dones++;
            if (cyc == 10) begin
                for (int j = 0; j < J; j++) begin
                    vectors++; if (got_row(j) !== exp_row(j)) begin miscompares++; $display("FAIL busy_row%0d: got %0d expected %0d", j, got_row(j), exp_row(j)); end
                end
            end
            if (cyc == 3 || cyc == 10) begin
                drive_noise();
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d expected 1", dones); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_not_queued: got %b expected 0", bus.busy); end
        vectors++; if (got_row(2) !== exp_row(2)) begin miscompares++; $display("FAIL busy_hold: got %0d expected %0d", got_row(2), exp_row(2)); end
    endtask

    task automatic test_back_to_back;
        logic signed [A-1:0] ex [3][J];
        logic [J*K*N-1:0]    gs [3];
        logic [K*N-1:0]      es [3];
        int job;
        for (int s = 0; s < 3; s++) begin
            rand_operands(-128, 127);
            drive_operands();
            gs[s] = bus.g_input;
            es[s] = bus.e_input;
            for (int j = 0; j < J; j++) ex[s][j] = exp_row(j);
        end
        bus.g_input = gs[0];
        bus.e_input = es[0];
        bus.start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 33; cyc++) begin
            vectors++; if (bus.done !== ((cyc % 11) == 10)) begin miscompares++; $display("FAIL b2b_done c%0d: got %b expected %b", cyc, bus.done, (cyc % 11) == 10); end
            if ((cyc % 11) == 1) begin
                vectors++; if (bus.o !== '0) begin miscompares++; $display("FAIL b2b_clear c%0d: got %h expected 0", cyc, bus.o); end
            end
            if ((cyc % 11) == 10) begin
                job = (cyc - 1) / 11;
                for (int j = 0; j < J; j++) begin
                    vectors++; if (got_row(j) !== ex[job][j]) begin miscompares++; $display("FAIL b2b_job%0d_row%0d: got %0d expected %0d", job, j, got_row(j), ex[job][j]); end
                end
            end
            if (cyc == 33) bus.start = 1'b0;
            else begin
                bus.g_input = gs[cyc / 11];
                bus.e_input = es[cyc / 11];
            end
            tick();
        end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_stop: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int lat;
        rand_operands(1, 127);
        start_job();
        repeat (4) tick();
        vectors++; if (got_row(0) !== exp_row(0)) begin miscompares++; $display("FAIL rstmid_row0_before: got %0d expected %0d", got_row(0), exp_row(0)); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
        vectors++; if (bus.o !== '0) begin miscompares++; $display("FAIL rstmid_o: got %h expected 0", bus.o); end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 4) rst_n = 1'b1;
            vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet c%0d: got done=%b busy=%b expected 0 0", c, bus.done, bus.busy); end
        end
        rand_operands(-128, 127);
        start_job();
        wait_done(lat);
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL rstmid_latency: got %0d expected 10", lat); end
        for (int j = 0; j < J; j++) begin
            vectors++; if (got_row(j) !== exp_row(j)) begin miscompares++; $display("FAIL rstmid_row%0d: got %0d expected %0d", j, got_row(j), exp_row(j)); end
        end
        tick();
    endtask

    task automatic test_input_change;
        int lat;
        for (int rep = 0; rep < 3; rep++) begin
            rand_operands(-128, 127);
            start_job();
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                if (bus.done === 1'b1) begin
                    lat = c;
                    break;
                end
                drive_noise();
                tick();
            end
            vectors++; if (lat !== 10) begin miscompares++; $display("FAIL chg%0d_latency: got %0d expected 10", rep, lat); end
            for (int j = 0; j < J; j++) begin
                vectors++; if (got_row(j) !== exp_row(j)) begin miscompares++; $display("FAIL chg%0d_row%0d: got %0d expected %0d", rep, j, got_row(j), exp_row(j)); end
            end
            tick();
        end
    endtask

    task automatic test_random;
        int lat;
        int pick;
        for (int rep = 0; rep < 12; rep++) begin
            rand_operands(-128, 127);
            // Bias some operands to the rails to hit sign and magnitude corners.
            for (int j = 0; j < J; j++)
                for (int k = 0; k < K; k++) begin
                    pick = int'($urandom_range(3));
                    if (pick == 0) Wm[j][k] = -128;
                    else if (pick == 1) Wm[j][k] = 127;
                end
            start_job();
            wait_done(lat);
            vectors++; if (lat !== 10) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d expected 10", rep, lat); end
            for (int j = 0; j < J; j++) begin
                vectors++; if (got_row(j) !== exp_row(j)) begin miscompares++; $display("FAIL rnd%0d_row%0d: got %0d expected %0d", rep, j, got_row(j), exp_row(j)); end
            end
            tick();
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.g_input = '0;
        bus.e_input = '0;
        test_reset();
        test_reference();
        test_extremes();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_input_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
